// File: rtl/tail_light_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tail_light_pkg
//  Brief    : Mode encoding, state type and thermometer helper shared by the
//             tail-light sequencer and its bench.
//  Revision : 1.0
// ============================================================================
package tail_light_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_LEFT  = 2'd1;
    localparam logic [1:0] MODE_RIGHT = 2'd2;
    localparam logic [1:0] MODE_HAZ   = 2'd3;

    // Widest lamp bank the thermometer helper can describe.
    localparam int MAX_LAMPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = MODE_IDLE,
        ST_LEFT  = MODE_LEFT,
        ST_RIGHT = MODE_RIGHT,
        ST_HAZ   = MODE_HAZ
    } mode_e;

    // Lowest `step` bits set; callers truncate to their own lamp count.
    function automatic logic [MAX_LAMPS-1:0] therm(input logic [31:0] step);
        logic [MAX_LAMPS-1:0] v;
        if (step >= 32'(MAX_LAMPS)) begin
            v = '1;
        end else begin
            v = (MAX_LAMPS'(1) << step) - MAX_LAMPS'(1);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : tail_light_seq_if
//  Brief    : Switch requests in, lamp drive and mode out.
//  Revision : 1.0
// ============================================================================
interface tail_light_seq_if #(
    parameter int LAMPS = 3
);
    logic             left;
    logic             right;
    logic             haz;
    logic             brake;
    logic [LAMPS-1:0] l_lamps;
    logic [LAMPS-1:0] r_lamps;
    logic [1:0]       mode;

    modport master (
        output left, right, haz, brake,
        input  l_lamps, r_lamps, mode
    );

    modport slave (
        input  left, right, haz, brake,
        output l_lamps, r_lamps, mode
    );
endinterface
`default_nettype wire

// File: rtl/tail_light_seq_step_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : step_tick_gen
//  Brief    : Animation prescaler; tick marks the last clk_en cycle of a step.
//  Revision : 1.0
// ============================================================================
module step_tick_gen #(
    parameter int STEP_DIV = 1
) (
    input  logic clk_en,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int DIV_W = $clog2(STEP_DIV) + 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;

    assign tick = (r_div_cnt == c_div_last);

    always_ff @(posedge clk_en) begin
        if (rst || clr) begin
            r_div_cnt <= '0;
        end else if (run) begin
            r_div_cnt <= tick ? '0 : r_div_cnt + DIV_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tail_light_seq
//  Brief    : Parametrised turn/hazard sequencer with steady brake overlay.
//  Revision : 1.0
// ============================================================================
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int STEP_DIV = 1
) (
    input  logic                   clk_en,
    input  logic                   rst,
    tail_light_seq_if.slave        bus
);
    localparam int STEP_W = $clog2(LAMPS) + 1;
    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(LAMPS);

    mode_e             r_mode,   w_mode_nxt;
    logic [STEP_W-1:0] r_step,   w_step_nxt;
    logic              r_haz_ph, w_haz_ph_nxt;
    logic              r_brake_q;

    logic w_hz;
    logic w_own;
    logic w_tick;
    logic w_run;
    logic w_clr;

    logic [LAMPS-1:0] w_therm;
    logic [LAMPS-1:0] w_brake_v;
    logic [LAMPS-1:0] w_l_lamps;
    logic [LAMPS-1:0] w_r_lamps;

    assign w_hz  = bus.haz | (bus.left & bus.right);
    assign w_own = (r_mode == ST_LEFT) ? bus.left : bus.right;

    // The prescaler restarts whenever the mode changes and idles at zero.
    assign w_run = (r_mode != ST_IDLE);
    assign w_clr = (r_mode == ST_IDLE) || (w_mode_nxt != r_mode);

    step_tick_gen #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick_gen (
        .clk_en (clk_en),
        .rst    (rst),
        .clr    (w_clr),
        .run    (w_run),
        .tick   (w_tick)
    );

    always_ff @(posedge clk_en) begin
        if (rst) begin
            r_mode    <= ST_IDLE;
            r_step    <= '0;
            r_haz_ph  <= 1'b0;
            r_brake_q <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_step    <= w_step_nxt;
            r_haz_ph  <= w_haz_ph_nxt;
            r_brake_q <= bus.brake;
        end
    end

    always_comb begin
        w_mode_nxt   = r_mode;
        w_step_nxt   = r_step;
        w_haz_ph_nxt = r_haz_ph;
        case (r_mode)
            ST_IDLE: begin
                if (w_hz) begin
                    w_mode_nxt   = ST_HAZ;
                    w_haz_ph_nxt = 1'b1;
                end else if (bus.left) begin
                    w_mode_nxt = ST_LEFT;
                    w_step_nxt = STEP_W'(1);
                end else if (bus.right) begin
                    w_mode_nxt = ST_RIGHT;
                    w_step_nxt = STEP_W'(1);
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (w_hz) begin
                    w_mode_nxt   = ST_HAZ;
                    w_haz_ph_nxt = 1'b1;
                    w_step_nxt   = '0;
                end else if (w_tick) begin
                    if (!w_own || (r_step == c_last_step)) begin
                        w_mode_nxt = ST_IDLE;
                        w_step_nxt = '0;
                    end else begin
                        w_step_nxt = r_step + STEP_W'(1);
                    end
                end
            end
            ST_HAZ: begin
                if (w_tick) begin
                    // Leave only from the dark phase so a flash is never cut short.
                    if (!r_haz_ph && !w_hz) begin
                        w_mode_nxt   = ST_IDLE;
                        w_haz_ph_nxt = 1'b0;
                    end else begin
                        w_haz_ph_nxt = ~r_haz_ph;
                    end
                end
            end
            default: begin
                w_mode_nxt   = ST_IDLE;
                w_step_nxt   = '0;
                w_haz_ph_nxt = 1'b0;
            end
        endcase
    end

    assign w_therm   = LAMPS'(therm(32'(r_step)));
    assign w_brake_v = {LAMPS{r_brake_q}};

    always_comb begin
        w_l_lamps = w_brake_v;
        w_r_lamps = w_brake_v;
        case (r_mode)
            ST_HAZ: begin
                w_l_lamps = {LAMPS{r_haz_ph}};
                w_r_lamps = {LAMPS{r_haz_ph}};
            end
            ST_LEFT:  w_l_lamps = w_therm;
            ST_RIGHT: w_r_lamps = w_therm;
            default: begin
                w_l_lamps = w_brake_v;
                w_r_lamps = w_brake_v;
            end
        endcase
    end

    assign bus.l_lamps = w_l_lamps;
    assign bus.r_lamps = w_r_lamps;
    assign bus.mode    = r_mode;
endmodule
`default_nettype wire

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Parametrised tail-light sequencer; next generation of the fixed 3-lamp turn-signal FSM.
- Drives LAMPS lamps per side with a thermometer sweep for left/right turn and a flashing hazard mode.
- Adds a steady brake overlay and a programmable step period (STEP_DIV clock-enable cycles per animation step).
- Sits between the switch/debounce logic and the lamp drivers, clocked by the divided clock clk_en.

Parameters:
- LAMPS, 3, lamps per side (>=1).
- STEP_DIV, 1, clk_en cycles per animation step (>=1).
- DIV_W, $clog2(STEP_DIV)+1, localparam, prescaler width.
- STEP_W, $clog2(LAMPS)+1, localparam, step counter width.

Ports:
- clk_en  in  1  block clock.
- rst  in  1  synchronous, active-high reset.
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- haz  in  1  hazard request, level.
- brake  in  1  brake pedal, level.
- l_lamps  out  LAMPS  left lamps; bit0 innermost (la), bit LAMPS-1 outermost.
- r_lamps  out  LAMPS  right lamps; bit0 innermost (ra).
- mode  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZ.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk_en. All state changes on posedge clk_en. rst has priority over every input.
- Registers: mode, step (0..LAMPS), div_cnt (0..STEP_DIV-1), haz_ph (1 = on), brake_q.
- Reset values: mode=IDLE, step=0, div_cnt=0, haz_ph=0, brake_q=0. Therefore l_lamps=0, r_lamps=0, mode=0. Reset mid-sequence returns to these values on the same edge.
- Outputs are a pure decode of the registers. There is no extra output lag: lamps reflect a state in the cycle after the edge that entered it.
- tick is asserted when div_cnt==STEP_DIV-1. div_cnt increments in LEFT/RIGHT/HAZ, wraps to 0 on tick, and is held at 0 in IDLE and on every mode entry. With STEP_DIV=1, tick is asserted every edge.
- Request decode:
  - hz = haz | (left & right).
  - Priority is hz > left > right.
- IDLE:
  - hz → HAZ, haz_ph=1.
  - else left → LEFT, step=1.
  - else right → RIGHT, step=1.
  - else stay.
  - Entry takes effect on the same edge that samples the request; no tick wait.
- LEFT/RIGHT:
  - hz preempts on the next edge, regardless of tick → HAZ, haz_ph=1, div_cnt=0.
  - On tick with the own request low → IDLE, step=0.
  - On tick with step<LAMPS → step+1.
  - On tick with step==LAMPS → IDLE; all lamps off for one IDLE cycle. The sweep then restarts if the request is still held.
  - Opposite-side request mid-sweep is ignored until IDLE.
- HAZ:
  - On tick, haz_ph toggles.
  - On tick with haz_ph==0 and hz low → IDLE. Exit happens only from the off phase.
- Lamp decode (thermometer): active side = ((1<<step)-1) truncated to LAMPS bits.
  - HAZ: both sides = {LAMPS{haz_ph}}; brake is ignored.
  - LEFT: l_lamps = thermometer; r_lamps = {LAMPS{brake_q}}.
  - RIGHT: mirror of LEFT.
  - IDLE: both sides = {LAMPS{brake_q}}.
- brake_q <= brake every edge. Brake changes never alter mode, step or div_cnt.
- LAMPS=1 is legal: sweep is step 1 then IDLE.

Decomposition:
- Package tail_light_pkg holds:
  - mode encoding constants MODE_IDLE=2'd0, MODE_LEFT=2'd1, MODE_RIGHT=2'd2, MODE_HAZ=2'd3;
  - a therm(step) function usable by RTL and bench.
- One sub-module: step_tick_gen (parameter STEP_DIV; inputs clk_en, rst, clr, run; output tick), owning div_cnt.

Test Plan:
- LAMPS=3, STEP_DIV=1: left held 8 edges after reset → l_lamps 001,011,111,000,001,011,111,000; r_lamps 000 throughout; mode 1,1,1,0,...
- LAMPS=3, STEP_DIV=2: right held → r_lamps 001,001,011,011,111,111,000; left dropped at step 2 → next tick gives 000, mode=0.
- LAMPS=3: left&right asserted together from IDLE → HAZ; both sides 111/000 alternating per step; release both during an on phase → one more off step, then IDLE.
- LAMPS=3: brake=1 during left sweep → r_lamps=111 from the edge after brake rises, left sweep unchanged; brake=1 in IDLE → both 111; brake in HAZ → flash pattern unaffected.
- LAMPS=3: haz asserted at step 2 of a left sweep → next edge mode=3, both sides 111, div_cnt=0.
- LAMPS=5, STEP_DIV=3: rst pulsed at step 3 → same edge gives all outputs 0, mode=0; left still held → sweep restarts at 00001 on the next edge.
